pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Evaluates ID-stage operand hazards,

---
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stall/flush outputs between pipeline and hazard controller
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_useRs;
    logic             ID_useRt;
    logic             ID_memWrite;
    logic             ID_isBranch;
    logic             ID_mduRead;
    logic             ID_mduStart;
    logic             EX_regWrite;
    logic             EX_memToReg;
    logic [4:0]       EX_rw;
    logic             MEM_memToReg;
    logic [4:0]       MEM_rw;
    logic             mispredict;
    logic             exc_req;

    logic             PC_STALL;
    logic             IF_ID_STALL;
    logic             IF_FLUSH;
    logic             ID_FLUSH;
    logic             EX_FLUSH;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;

    // master: pipeline side; slave: the hazard controller
    modport master (
        output ID_rs, ID_rt, ID_useRs, ID_useRt, ID_memWrite, ID_isBranch,
               ID_mduRead, ID_mduStart, EX_regWrite, EX_memToReg, EX_rw,
               MEM_memToReg, MEM_rw, mispredict, exc_req,
        input  PC_STALL, IF_ID_STALL, IF_FLUSH, ID_FLUSH, EX_FLUSH,
               mdu_busy, stall_cycles
    );

    modport slave (
        input  ID_rs, ID_rt, ID_useRs, ID_useRt, ID_memWrite, ID_isBranch,
               ID_mduRead, ID_mduStart, EX_regWrite, EX_memToReg, EX_rw,
               MEM_memToReg, MEM_rw, mispredict, exc_req,
        output PC_STALL, IF_ID_STALL, IF_FLUSH, ID_FLUSH, EX_FLUSH,
               mdu_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with MDU occupancy tracking and stall perf counter
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hif
);

    localparam int MC_W = $clog2(MDU_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic [MC_W-1:0]  mdu_cnt;
    logic [MC_W-1:0]  mdu_cnt_nxt;
    logic             mdu_busy_q;
    logic [CNT_W-1:0] stall_cnt;

    logic ex_rs_match;
    logic ex_rt_match;
    logic mem_rs_match;
    logic mem_rt_match;
    logic hz_lu;
    logic hz_br;
    logic hz_md;
    logic stall;
    logic mdu_issue;

    // Register 0 is hardwired, so a zero destination never matches anything
    assign ex_rs_match  = (hif.EX_rw  != 5'd0) && hif.ID_useRs && (hif.ID_rs == hif.EX_rw);
    assign ex_rt_match  = (hif.EX_rw  != 5'd0) && hif.ID_useRt && (hif.ID_rt == hif.EX_rw);
    assign mem_rs_match = (hif.MEM_rw != 5'd0) && hif.ID_useRs && (hif.ID_rs == hif.MEM_rw);
    assign mem_rt_match = (hif.MEM_rw != 5'd0) && hif.ID_useRt && (hif.ID_rt == hif.MEM_rw);

    // Store data is forwarded at MEM, so a store's rt never waits on a load in EX
    assign hz_lu = hif.EX_memToReg && (ex_rs_match || (ex_rt_match && !hif.ID_memWrite));

    assign hz_br = hif.ID_isBranch &&
                   ((hif.EX_regWrite  && (ex_rs_match  || ex_rt_match)) ||
                    (hif.MEM_memToReg && (mem_rs_match || mem_rt_match)));

    assign hz_md = (state == BUSY) && (hif.ID_mduRead || hif.ID_mduStart) &&
                   (mdu_cnt != '0);

    assign stall = hz_lu || hz_br || hz_md;

    // An mult/div issues only on the cycle it actually leaves ID on the right path
    assign mdu_issue = hif.ID_mduStart && !stall && !hif.exc_req && !hif.mispredict;

    always_comb begin
        hif.PC_STALL    = 1'b0;
        hif.IF_ID_STALL = 1'b0;
        hif.IF_FLUSH    = 1'b0;
        hif.ID_FLUSH    = 1'b0;
        hif.EX_FLUSH    = 1'b0;
        if (hif.exc_req) begin
            hif.IF_FLUSH = 1'b1;
            hif.ID_FLUSH = 1'b1;
            hif.EX_FLUSH = 1'b1;
        end else if (hif.mispredict) begin
            hif.IF_FLUSH = 1'b1;
            hif.ID_FLUSH = 1'b1;
        end else if (stall) begin
            hif.PC_STALL    = 1'b1;
            hif.IF_ID_STALL = 1'b1;
            hif.ID_FLUSH    = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        unique case (state)
            IDLE: begin
                if (mdu_issue) begin
                    state_nxt   = BUSY;
                    mdu_cnt_nxt = MC_W'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (hif.exc_req) begin
                    state_nxt   = IDLE;
                    mdu_cnt_nxt = '0;
                end else if (mdu_cnt == MC_W'(1)) begin
                    state_nxt   = DONE;
                    mdu_cnt_nxt = '0;
                end else begin
                    mdu_cnt_nxt = mdu_cnt - MC_W'(1);
                end
            end
            DONE: begin
                if (mdu_issue) begin
                    state_nxt   = BUSY;
                    mdu_cnt_nxt = MC_W'(MDU_LAT - 1);
                end else begin
                    state_nxt   = IDLE;
                    mdu_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mdu_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mdu_cnt    <= '0;
            mdu_busy_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            mdu_cnt    <= mdu_cnt_nxt;
            mdu_busy_q <= (state_nxt == BUSY);
            if (hif.PC_STALL) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign hif.mdu_busy     = mdu_busy_q;
    assign hif.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   busy_n;
    int   stall_n;
    logic [4:0] outs;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hif ();

    pipeline_hazard_ctrl #(.MDU_LAT(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {PC_STALL, IF_ID_STALL, IF_FLUSH, ID_FLUSH, EX_FLUSH}
    assign outs = {hif.PC_STALL, hif.IF_ID_STALL, hif.IF_FLUSH, hif.ID_FLUSH, hif.EX_FLUSH};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hif.ID_rs        = 5'd0;
        hif.ID_rt        = 5'd0;
        hif.ID_useRs     = 1'b0;
        hif.ID_useRt     = 1'b0;
        hif.ID_memWrite  = 1'b0;
        hif.ID_isBranch  = 1'b0;
        hif.ID_mduRead   = 1'b0;
        hif.ID_mduStart  = 1'b0;
        hif.EX_regWrite  = 1'b0;
        hif.EX_memToReg  = 1'b0;
        hif.EX_rw        = 5'd0;
        hif.MEM_memToReg = 1'b0;
        hif.MEM_rw       = 5'd0;
        hif.mispredict   = 1'b0;
        hif.exc_req      = 1'b0;
    endtask

    task automatic set_lu_r5();
        hif.EX_memToReg = 1'b1;
        hif.EX_rw       = 5'd5;
        hif.ID_rs       = 5'd5;
        hif.ID_useRs    = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clr();
        #3;
        chk("reset_outs", 32'(outs), 32'h0);
        chk("reset_busy", 32'(hif.mdu_busy), 32'h0);
        chk("reset_cnt", hif.stall_cycles, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // load-use on rs: one stall cycle, then lw moves to MEM and no stall
        set_lu_r5();
        hif.ID_rt    = 5'd1;
        hif.ID_useRt = 1'b1;
        #2 chk("lu_rs_stall", 32'(outs), 32'b11010);
        tick();
        hif.EX_memToReg  = 1'b0;
        hif.EX_rw        = 5'd0;
        hif.MEM_memToReg = 1'b1;
        hif.MEM_rw       = 5'd5;
        #2 chk("lu_rs_release", 32'(outs), 32'b00000);
        chk("lu_rs_cnt", hif.stall_cycles, 32'd1);

        // store data of a load result is forwarded; reg 0 never hazards
        clr();
        hif.EX_memToReg = 1'b1;
        hif.EX_rw       = 5'd5;
        hif.ID_rs       = 5'd2;
        hif.ID_useRs    = 1'b1;
        hif.ID_rt       = 5'd5;
        hif.ID_useRt    = 1'b1;
        hif.ID_memWrite = 1'b1;
        #2 chk("sw_fwd_nostall", 32'(outs), 32'b00000);
        hif.EX_rw       = 5'd0;
        hif.ID_rs       = 5'd0;
        hif.ID_rt       = 5'd0;
        hif.ID_memWrite = 1'b0;
        #2 chk("r0_nostall", 32'(outs), 32'b00000);
        hif.EX_rw = 5'd7;
        hif.ID_rt = 5'd7;
        #2 chk("lu_rt_stall", 32'(outs), 32'b11010);
        tick();
        chk("lu_rt_cnt", hif.stall_cycles, 32'd2);

        // branch operands: EX ALU write, then MEM load
        clr();
        hif.ID_isBranch = 1'b1;
        hif.ID_rs       = 5'd3;
        hif.ID_rt       = 5'd4;
        hif.ID_useRs    = 1'b1;
        hif.ID_useRt    = 1'b1;
        hif.EX_regWrite = 1'b1;
        hif.EX_rw       = 5'd4;
        #2 chk("br_ex_stall", 32'(outs), 32'b11010);
        tick();
        hif.EX_regWrite  = 1'b0;
        hif.EX_rw        = 5'd0;
        hif.MEM_memToReg = 1'b1;
        hif.MEM_rw       = 5'd4;
        #2 chk("br_mem_stall", 32'(outs), 32'b11010);
        tick();
        hif.MEM_memToReg = 1'b0;
        #2 chk("br_release", 32'(outs), 32'b00000);
        chk("br_cnt", hif.stall_cycles, 32'd4);
        hif.ID_isBranch = 1'b0;
        hif.EX_regWrite = 1'b1;
        hif.EX_rw       = 5'd4;
        #2 chk("alu_nobranch_nostall", 32'(outs), 32'b00000);

        // flushes override a simultaneous stall and do not count as stall cycles
        clr();
        set_lu_r5();
        hif.mispredict = 1'b1;
        #2 chk("lu_mispredict", 32'(outs), 32'b00110);
        tick();
        hif.mispredict = 1'b0;
        hif.exc_req    = 1'b1;
        #2 chk("lu_exc", 32'(outs), 32'b00111);
        tick();
        chk("flush_cnt", hif.stall_cycles, 32'd4);

        // mispredicted mult must not start the MDU
        clr();
        hif.ID_mduStart = 1'b1;
        hif.mispredict  = 1'b1;
        tick();
        clr();
        #2 chk("mdu_mispredict_nostart", 32'(hif.mdu_busy), 32'h0);

        // mult at cycle 0, mfhi reaches ID at cycle 3
        hif.ID_mduStart = 1'b1;
        #2 chk("mdu_issue_outs", 32'(outs), 32'b00000);
        tick();
        hif.ID_mduStart = 1'b0;
        busy_n  = 0;
        stall_n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) hif.ID_mduRead = 1'b1;
            #2;
            if (hif.mdu_busy) busy_n++;
            if (hif.PC_STALL) stall_n++;
            if (i == 1)  chk("mdu_busy_c1", 32'(hif.mdu_busy), 32'h1);
            if (i == 31) chk("mdu_stall_c31", 32'(outs), 32'b11010);
            if (i == 32) chk("mdu_done_busy", 32'(hif.mdu_busy), 32'h0);
            if (i == 32) chk("mdu_done_outs", 32'(outs), 32'b00000);
            tick();
        end
        chk("mdu_busy_cycles", busy_n, 32'd31);
        chk("mdu_stall_cycles", stall_n, 32'd29);
        chk("mdu_cnt_total", hif.stall_cycles, 32'd33);

        // exception during BUSY aborts the MDU
        clr();
        hif.ID_mduStart = 1'b1;
        tick();
        hif.ID_mduStart = 1'b0;
        tick();
        tick();
        chk("exc_pre_busy", 32'(hif.mdu_busy), 32'h1);
        hif.exc_req = 1'b1;
        #2 chk("exc_busy_outs", 32'(outs), 32'b00111);
        tick();
        hif.exc_req    = 1'b0;
        hif.ID_mduRead = 1'b1;
        #2 chk("exc_busy_cleared", 32'(hif.mdu_busy), 32'h0);
        chk("exc_mfhi_nostall", 32'(outs), 32'b00000);
        tick();

        // a stalled mult waits in ID and starts once it leaves
        clr();
        set_lu_r5();
        hif.ID_mduStart = 1'b1;
        #2 chk("mdu_stalled_start", 32'(outs), 32'b11010);
        tick();
        chk("mdu_stalled_nobusy", 32'(hif.mdu_busy), 32'h0);
        clr();
        hif.ID_mduStart = 1'b1;
        tick();
        hif.ID_mduStart = 1'b0;
        hif.ID_mduRead  = 1'b1;
        chk("mdu_late_busy", 32'(hif.mdu_busy), 32'h1);
        repeat (21) tick();

        // asynchronous reset mid-BUSY
        #2 chk("pre_rst_stall", 32'(outs), 32'b11010);
        rst = 1'b0;
        #1;
        chk("rst_outs", 32'(outs), 32'b00000);
        chk("rst_busy", 32'(hif.mdu_busy), 32'h0);
        chk("rst_cnt", hif.stall_cycles, 32'd0);
        #2 rst = 1'b1;
        tick();
        #2 chk("post_rst_idle_nostall", 32'(outs), 32'b00000);
        chk("post_rst_busy", 32'(hif.mdu_busy), 32'h0);
        hif.ID_mduRead  = 1'b0;
        hif.ID_mduStart = 1'b1;
        tick();
        hif.ID_mduStart = 1'b0;
        chk("post_rst_restart", 32'(hif.mdu_busy), 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
